// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store front-end for a word-addressed data memory
//
// Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into single-word
// memory accesses. Sub-word stores use read-modify-write. Loads extract the
// addressed lane and sign- or zero-extend it.
//
// Ports:
//   i_clk, i_reset    clock (posedge) and synchronous active-high reset
//   i_req             request strobe, sampled only while idle
//   i_mem_wr/i_mem_rd store/load select (both set -> store, neither -> ignored)
//   i_width           00 byte, 01 half, 1x word
//   i_signed          sign-extend sub-word loads when set
//   i_addr, i_wdata   byte address and store data (sub-word data in low bits)
//   o_busy            high whenever an operation is in progress
//   o_done            one-cycle completion pulse
//   o_misaligned      alignment fault, valid with o_done
//   o_rdata           extended load result, held until the next load completes
//   o_mem_wr_rd       to memory: 1 write, 0 read
//   o_mem_addr        to memory: word index
//   o_mem_wdata       to memory: write word
//   i_mem_rdata       from memory: read word, sampled at the end of a read cycle
module mem_access_unit #(
  parameter int MEM_ADDR_SIZE = 5,
  parameter int DATA_SIZE     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req,
  input  logic                     i_mem_wr,
  input  logic                     i_mem_rd,
  input  logic [1:0]               i_width,
  input  logic                     i_signed,
  input  logic [31:0]              i_addr,
  input  logic [DATA_SIZE-1:0]     i_wdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_misaligned,
  output logic [DATA_SIZE-1:0]     o_rdata,
  output logic                     o_mem_wr_rd,
  output logic [MEM_ADDR_SIZE-1:0] o_mem_addr,
  output logic [DATA_SIZE-1:0]     o_mem_wdata,
  input  logic [DATA_SIZE-1:0]     i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_next;

  // Request captured at acceptance; the request inputs may change afterwards.
  logic        op_store;
  logic [1:0]  op_width;
  logic        op_signed;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic        accept;
  logic        req_byte;
  logic        req_word;
  logic        req_mis;
  logic [DATA_SIZE-1:0] merged_word;
  logic [DATA_SIZE-1:0] load_value;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Address bits above the memory's range wrap around.
  logic unused_addr;
  assign unused_addr = ^i_addr[31:MEM_ADDR_SIZE+2];

  assign o_busy = (state != IDLE);

  always_comb begin
    accept   = i_req & (i_mem_wr | i_mem_rd);
    req_byte = (i_width == 2'b00);
    req_word = i_width[1];
    if (i_width == 2'b01) req_mis = i_addr[0];
    else if (req_word)    req_mis = (i_addr[1:0] != 2'b00);
    else                  req_mis = 1'b0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mis)                                    state_next = DONE;
          else if (i_mem_wr && !req_byte && i_width != 2'b01) state_next = WRITE;
          else                                            state_next = READ;
        end
      end
      READ:    state_next = op_store ? WRITE : DONE;
      WRITE:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Lane replacement for sub-word stores; word stores never pass through READ.
  always_comb begin
    merged_word = i_mem_rdata;
    if (op_width == 2'b00)
      merged_word[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
    else if (op_width == 2'b01)
      merged_word[{op_lane[1], 4'b0000} +: 16] = op_wdata[15:0];
  end

  always_comb begin
    load_byte = i_mem_rdata[{op_lane, 3'b000} +: 8];
    load_half = i_mem_rdata[{op_lane[1], 4'b0000} +: 16];
    case (op_width)
      2'b00:   load_value = {{24{op_signed & load_byte[7]}}, load_byte};
      2'b01:   load_value = {{16{op_signed & load_half[15]}}, load_half};
      default: load_value = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_mem_wr_rd  <= 1'b0;
      o_rdata      <= '0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      op_store     <= 1'b0;
      op_width     <= 2'b00;
      op_signed    <= 1'b0;
      op_lane      <= 2'b00;
      op_wdata     <= 16'h0000;
    end else begin
      // Strobes follow the state being entered so they line up with it.
      o_done      <= (state_next == DONE);
      o_mem_wr_rd <= (state_next == WRITE);
      case (state)
        IDLE: begin
          if (accept) begin
            op_store     <= i_mem_wr;
            op_width     <= i_width;
            op_signed    <= i_signed;
            op_lane      <= i_addr[1:0];
            op_wdata     <= i_wdata[15:0];
            o_misaligned <= req_mis;
            if (!req_mis) o_mem_addr <= i_addr[MEM_ADDR_SIZE+1:2];
            if (!req_mis && i_mem_wr && req_word) o_mem_wdata <= i_wdata;
          end
        end
        READ: begin
          if (op_store) o_mem_wdata <= merged_word;
          else          o_rdata     <= load_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int AW = 5;

  logic          clk;
  logic          i_reset;
  logic          i_req;
  logic          i_mem_wr;
  logic          i_mem_rd;
  logic [1:0]    i_width;
  logic          i_signed;
  logic [31:0]   i_addr;
  logic [31:0]   i_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_misaligned;
  logic [31:0]   o_rdata;
  logic          o_mem_wr_rd;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic [31:0] ref_rdata;

  int vectors = 0;
  int errors  = 0;

  mem_access_unit #(.MEM_ADDR_SIZE(AW), .DATA_SIZE(32)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_mem_wr     (i_mem_wr),
    .i_mem_rd     (i_mem_rd),
    .i_width      (i_width),
    .i_signed     (i_signed),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_misaligned (o_misaligned),
    .o_rdata      (o_rdata),
    .o_mem_wr_rd  (o_mem_wr_rd),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory acting mid-cycle on the registered strobe/address.
  always @(negedge clk) begin
    if (o_mem_wr_rd) mem[o_mem_addr] = o_mem_wdata;
    else             i_mem_rdata = mem[o_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b00) return 1'b0;
    if (w == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] oldw, input logic [1:0] w,
                                              input logic [31:0] a, input logic [31:0] d);
    int sh;
    if (w == 2'b00) begin
      sh = 8 * a[1:0];
      return (oldw & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end
    if (w == 2'b01) begin
      sh = 16 * a[1];
      return (oldw & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] w,
                                             input bit sg, input logic [31:0] a);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (word >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (w == 2'b01) begin
      v = (word >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic scramble_inputs();
    i_mem_wr = 1'($urandom);
    i_mem_rd = 1'($urandom);
    i_width  = 2'($urandom);
    i_signed = 1'($urandom);
    i_addr   = $urandom;
    i_wdata  = $urandom;
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [1:0] w, input bit sg,
                       input logic [31:0] a, input logic [31:0] d);
    int          idx  = int'(a[6:2]);
    bit          mis  = model_mis(w, a);
    bit          sub  = (w == 2'b00) || (w == 2'b01);
    logic [31:0] neww = ref_mem[idx];
    int          exp_lat;
    int          exp_wr;
    int          edges;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    if (mis) begin
      exp_lat = 1; exp_wr = 0;
    end else if (wr) begin
      neww = model_store(ref_mem[idx], w, a, d);
      ref_mem[idx] = neww;
      exp_lat = sub ? 3 : 2; exp_wr = 1;
    end else begin
      ref_rdata = model_load(ref_mem[idx], w, sg, a);
      exp_lat = 2; exp_wr = 0;
    end

    i_mem_wr = wr; i_mem_rd = rd; i_width = w; i_signed = sg; i_addr = a; i_wdata = d;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    scramble_inputs();
    edges = 1;
    while (o_done !== 1'b1 && edges < 8) begin
      if (o_mem_wr_rd === 1'b1) begin
        wr_cnt++; wr_addr = 32'(o_mem_addr); wr_data = o_mem_wdata;
      end
      @(posedge clk); #1;
      edges++;
    end
    check("done_seen", 32'(o_done), 32'd1);
    check("latency", edges, exp_lat);
    check("misaligned", 32'(o_misaligned), 32'(mis));
    check("busy_at_done", 32'(o_busy), 32'd1);
    check("wr_rd_at_done", 32'(o_mem_wr_rd), 32'd0);
    check("rdata", o_rdata, ref_rdata);
    check("write_cycles", wr_cnt, exp_wr);
    if (exp_wr == 1) begin
      check("write_addr", wr_addr, idx);
      check("write_data", wr_data, neww);
    end
    check("mem_word", mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
    check("done_pulse_end", 32'(o_done), 32'd0);
    check("idle_after", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int          idx1;
    int          idx2;
    int          done_cnt;
    int          busy_falls;
    int          wr_seen;
    bit          prev_busy;
    logic [31:0] a;
    logic [31:0] saved;
    bit          wr;
    bit          rd;

    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    ref_rdata   = 32'h0;
    i_mem_rdata = 32'h0;
    i_reset = 1'b1; i_req = 1'b0;
    i_mem_wr = 1'b0; i_mem_rd = 1'b0; i_width = 2'b00; i_signed = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_mis", 32'(o_misaligned), 32'd0);
    check("rst_wr_rd", 32'(o_mem_wr_rd), 32'd0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_addr", 32'(o_mem_addr), 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    i_reset = 1'b0;

    // SW then LW of the same word.
    do_op(1, 0, 2'b11, 0, 32'h08, 32'h11223344);
    do_op(0, 1, 2'b11, 1, 32'h08, 32'h0);
    check("lw_value", o_rdata, 32'h11223344);

    // SB into lane 1 by read-modify-write.
    do_op(1, 0, 2'b00, 0, 32'h09, 32'hFFFFFFAB);
    check("sb_merge", mem[2], 32'h1122AB44);

    // Sign/zero extension of sub-word loads; both strobes set means store.
    do_op(1, 1, 2'b11, 0, 32'h00, 32'h00008080);
    do_op(0, 1, 2'b00, 1, 32'h00, 32'h0);
    check("lb_signed", o_rdata, 32'hFFFFFF80);
    do_op(0, 1, 2'b00, 0, 32'h00, 32'h0);
    check("lbu", o_rdata, 32'h00000080);
    do_op(0, 1, 2'b01, 1, 32'h00, 32'h0);
    check("lh_signed", o_rdata, 32'hFFFF8080);
    do_op(0, 1, 2'b01, 0, 32'h02, 32'h0);
    check("lhu_upper", o_rdata, 32'h00000000);

    // Misaligned half load and word store; width 10 behaves as word.
    do_op(0, 1, 2'b01, 1, 32'h05, 32'h0);
    do_op(1, 0, 2'b11, 0, 32'h06, 32'hDEADBEEF);
    do_op(1, 0, 2'b10, 0, 32'h0E, 32'hCAFEF00D);

    // Strobe with neither wr nor rd is ignored.
    i_mem_wr = 1'b0; i_mem_rd = 1'b0; i_width = 2'b11; i_addr = 32'h10; i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    check("noop_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check("noop_done", 32'(o_done), 32'd0);

    // Second request while busy must be dropped.
    idx1 = int'($urandom_range(0, 31));
    idx2 = (idx1 + 1) % 32;
    a = 32'(idx1 * 4 + int'($urandom_range(0, 3)));
    saved = 32'($urandom);
    ref_mem[idx1] = model_store(ref_mem[idx1], 2'b00, a, saved);
    i_mem_wr = 1'b1; i_mem_rd = 1'b0; i_width = 2'b00; i_addr = a; i_wdata = saved; i_req = 1'b1;
    @(posedge clk); #1;
    i_width = 2'b11; i_addr = 32'(idx2 * 4); i_wdata = ~ref_mem[idx2];
    done_cnt = 0; busy_falls = 0; prev_busy = o_busy;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) i_req = 1'b0;
      if (o_done === 1'b1) done_cnt++;
      if (prev_busy && o_busy === 1'b0) busy_falls++;
      prev_busy = o_busy;
    end
    i_req = 1'b0;
    check("drop_done_count", done_cnt, 1);
    check("drop_busy_falls", busy_falls, 1);
    check("drop_first_word", mem[idx1], ref_mem[idx1]);
    check("drop_second_word", mem[idx2], ref_mem[idx2]);

    // Reset during the READ of an SH abandons it.
    idx1 = int'($urandom_range(0, 31));
    i_mem_wr = 1'b1; i_mem_rd = 1'b0; i_width = 2'b01; i_addr = 32'(idx1 * 4 + 2);
    i_wdata = $urandom; i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    check("sh_in_read", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    ref_rdata = 32'h0;
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    done_cnt = 0; wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_mem_wr_rd === 1'b1) wr_seen++;
      if (o_done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    check("rst_mid_writes", wr_seen, 0);
    check("rst_mid_dones", done_cnt, 0);
    check("rst_mid_mem", mem[idx1], ref_mem[idx1]);
    do_op(0, 1, 2'b11, 0, 32'(idx1 * 4), 32'h0);

    // Randomized mix, including wrap-around upper address bits.
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      do_op(wr, rd, 2'($urandom), 1'($urandom), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
